edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//   Detects rising edges on N independent level inputs and queues one pending
//   event per channel. Pending events are granted round-robin to one consumer
//   over a valid/ready handshake. Events lost to overflow are flagged per
//   channel and counted. Sits between raw status/strobe lines and a single
//   shared event-handling engine.
// PARAMETERS
//   N      4  number of input channels (N >= 2)
//   CNT_W  8  width of the saturating dropped-event counter
// PORTS
//   clk        in   1              clock, all state updates on posedge
//   rst        in   1              synchronous reset, active-high
//   a          in   N              level inputs, one per channel
//   out_valid  out  1              event offered to consumer
//   out_id     out  $clog2(N)      channel index of offered event
//   out_ready  in   1              consumer accepts; fire = out_valid & out_ready
//   overflow   out  N              sticky per-channel drop flag
//   drop_cnt   out  CNT_W          saturating count of dropped events
//   drop_clr   in   1              clears overflow and drop_cnt
// BEHAVIOUR
// - Reset (rst=1 at posedge): a_r=0, pending=0, state=IDLE, ptr=0,
//   out_valid=0, out_id=0, overflow=0, drop_cnt=0. Reset applied mid-OFFER
//   abandons the offered event; out_valid=0 from the next cycle.
// - Edge: a_r[i] <= a[i] every cycle; edge[i] = a[i] & ~a_r[i]. A line held
//   high through reset yields one edge on the first cycle after reset.
// - Pending: at posedge, pending[i] <= (pending[i] & ~load[i]) | edge[i].
//   load[i] is 1 when channel i moves into the output register this cycle.
//   edge and load on the same channel in the same cycle: pending stays 1, no
//   drop.
// - Drop: edge[i] & pending[i] & ~load[i] -> overflow[i] <= 1 and
//   drop_cnt += 1, saturating at 2**CNT_W-1. Multiple channels dropping in the
//   same cycle add their total count (saturating).
// - drop_clr: clears overflow and drop_cnt. Drops in the same cycle win:
//   overflow holds only the new bits and drop_cnt equals the new count.
// - Select: sel = first i with pending[i], searching ptr, ptr+1, ... N-1,
//   0, ... (wrapping).
// - FSM, 2 states:
//   IDLE:  out_valid=0. If any pending: load sel, out_id <= sel,
//          out_valid <= 1, go to OFFER.
//   OFFER: out_valid=1. out_id is held stable until fire.
//          On fire: ptr <= (out_id+1) mod N. Compute sel from the new ptr and
//          the current pending. If any pending: load sel and stay in OFFER
//          (back-to-back, no bubble). Else go to IDLE.
//          No fire: no load, state unchanged.
// - Latency: a rises before posedge k -> pending set at posedge k ->
//   out_valid=1 with out_id=i after posedge k+1 (when IDLE).
// - out_valid never drops without fire, except under rst.
// TESTING
// 1. After reset, a=0000 -> 0001 at posedge k, out_ready=1 -> out_valid=1 and
//    out_id=0 for exactly one cycle after posedge k+1; drop_cnt=0.
// 2. a 0000 -> 1111 in one cycle, out_ready=1 -> out_id 0,1,2,3 on four
//    consecutive cycles, then out_valid=0.
// 3. out_ready=0, channel 1 offered. Channel 1 pulses 010 twice more ->
//    first pulse re-pends, second pulse drops: overflow=0010, drop_cnt=1,
//    out_id stays 1.
// 4. Channels 0 and 2 re-pulse each time they are granted, out_ready=1 ->
//    grant order 0,2,0,2,...; channel 2 is never starved.
// 5. CNT_W=2, force 5 drops on channel 3 -> drop_cnt=3 (saturated). Then
//    drop_clr=1 alone -> drop_cnt=0, overflow=0000.
// 6. rst=1 while in OFFER with channels 1,2 pending -> next cycle
//    out_valid=0, pending=0; first event after release comes from ptr=0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Rising-edge event queue with round-robin grant to a single consumer.
// Each channel holds at most one pending event; a new edge on a channel
// whose event is still pending (and not being granted) is dropped and
// recorded in the sticky overflow flags and the saturating drop counter.
module edge_event_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_id,
  input  logic                 out_ready,
  output logic [N-1:0]         overflow,
  output logic [CNT_W-1:0]     drop_cnt,
  input  logic                 drop_clr
);

  localparam int          IW    = $clog2(N);
  localparam int unsigned NU    = N;
  localparam int          SUM_W = CNT_W + IW + 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [N-1:0]     a_r;
  logic [N-1:0]     pending;
  logic [IW-1:0]    ptr;

  logic [N-1:0]     edge_v;
  logic [N-1:0]     load;
  logic [N-1:0]     drops;
  logic [IW-1:0]    base;
  logic [IW-1:0]    next_id;
  logic [IW-1:0]    sel;
  logic             found;
  logic             fire;
  logic             do_load;
  logic [SUM_W-1:0] drop_num;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;

  // Edge detect, handshake and round-robin search base.
  // On fire the search starts just past the channel being retired, so the
  // next grant can be loaded in the same cycle without a bubble.
  always_comb begin
    edge_v  = a & ~a_r;
    fire    = out_valid & out_ready;
    next_id = (out_id == IW'(N - 1)) ? '0 : out_id + 1'b1;
    base    = (state == OFFER) ? next_id : ptr;
    do_load = (state == IDLE) | fire;
  end

  // Wrapping first-pending search starting at base.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      int unsigned idx;
      idx = (32'(base) + k) % NU;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  // Grant vector, drop detection and saturating drop count.
  always_comb begin
    load = '0;
    if (do_load && found) load[sel] = 1'b1;
    drops    = edge_v & pending & ~load;
    drop_num = '0;
    for (int unsigned k = 0; k < NU; k++) drop_num = drop_num + SUM_W'(drops[k]);
    sum = (drop_clr ? '0 : SUM_W'(drop_cnt)) + drop_num;
    if (sum > SUM_W'({CNT_W{1'b1}})) cnt_next = '1;
    else                             cnt_next = sum[CNT_W-1:0];
  end

  // State, pending queue, drop bookkeeping and registered output offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      pending   <= '0;
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      overflow  <= '0;
      drop_cnt  <= '0;
    end else begin
      a_r      <= a;
      pending  <= (pending & ~load) | edge_v;
      overflow <= (drop_clr ? '0 : overflow) | drops;
      drop_cnt <= cnt_next;
      case (state)
        IDLE: begin
          if (found) begin
            out_id    <= sel;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (fire) begin
            ptr <= next_id;
            if (found) begin
              out_id <= sel;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed testbench for edge_event_arbiter. Two instances share stimulus:
// dut uses the default counter width, dut2 a 2-bit counter for saturation.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic       out_ready;
  logic       drop_clr;

  logic       out_valid, out_valid2;
  logic [1:0] out_id, out_id2;
  logic [3:0] overflow, overflow2;
  logic [7:0] drop_cnt;
  logic [1:0] drop_cnt2;

  int checks   = 0;
  int failures = 0;

  edge_event_arbiter #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .out_valid(out_valid), .out_id(out_id),
    .out_ready(out_ready), .overflow(overflow), .drop_cnt(drop_cnt),
    .drop_clr(drop_clr)
  );

  edge_event_arbiter #(.N(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .out_valid(out_valid2), .out_id(out_id2),
    .out_ready(out_ready), .overflow(overflow2), .drop_cnt(drop_cnt2),
    .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a = '0; out_ready = 1'b0; drop_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_out: valid=%b id=%0d, required valid=0 id=0", out_valid, out_id);
    end
    checks++;
    if (overflow !== 4'b0000 || drop_cnt !== 8'd0 || drop_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_drop: ovf=%b cnt=%0d cnt2=%0d, required 0000/0/0", overflow, drop_cnt, drop_cnt2);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    a = 4'b0001;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_latency: valid=%b after first edge, required 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      failures++;
      $display("FAIL single_offer: valid=%b id=%0d, required valid=1 id=0", out_valid, out_id);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL single_done: valid=%b cnt=%0d, required valid=0 cnt=0", out_valid, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    a = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(i)) begin
        failures++;
        $display("FAIL b2b_grant%0d: valid=%b id=%0d, required valid=1 id=%0d", i, out_valid, out_id, i);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    a = 4'b0010;
    step();
    a = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      failures++;
      $display("FAIL ovf_offer: valid=%b id=%0d, required valid=1 id=1", out_valid, out_id);
    end
    a = 4'b0010; step(); a = 4'b0000; step();
    checks++;
    if (overflow !== 4'b0000 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL ovf_repend: ovf=%b cnt=%0d, required 0000/0", overflow, drop_cnt);
    end
    a = 4'b0010; step(); a = 4'b0000; step();
    checks++;
    if (overflow !== 4'b0010 || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL ovf_drop: ovf=%b cnt=%0d, required 0010/1", overflow, drop_cnt);
    end
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      failures++;
      $display("FAIL ovf_hold: valid=%b id=%0d, required valid=1 id=1", out_valid, out_id);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    a = 4'b0101;
    step();
    a = 4'b0000;
    step();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_id;
      exp_id = (i % 2 == 0) ? 2'd0 : 2'd2;
      checks++;
      if (out_valid !== 1'b1 || out_id !== exp_id) begin
        failures++;
        $display("FAIL rr_grant%0d: valid=%b id=%0d, required valid=1 id=%0d", i, out_valid, out_id, exp_id);
      end
      a = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      step();
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rr_nodrop: cnt=%0d, required 0", drop_cnt);
    end
  endtask

  task automatic test_multi_drop();
    do_reset();
    a = 4'b1111;
    step();
    a = 4'b0000;
    step();
    a = 4'b1111; step(); a = 4'b0000; step();
    checks++;
    if (overflow !== 4'b1110 || drop_cnt !== 8'd3 || drop_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL multi_drop1: ovf=%b cnt=%0d cnt2=%0d, required 1110/3/3", overflow, drop_cnt, drop_cnt2);
    end
    a = 4'b1111; step(); a = 4'b0000; step();
    checks++;
    if (overflow !== 4'b1111 || drop_cnt !== 8'd7 || drop_cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL multi_drop2: ovf=%b cnt=%0d cnt2=%0d, required 1111/7/3", overflow, drop_cnt, drop_cnt2);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    a = 4'b1000;
    step();
    a = 4'b0000;
    step();
    a = 4'b1000; step(); a = 4'b0000; step();
    for (int i = 0; i < 5; i++) begin
      a = 4'b1000; step(); a = 4'b0000; step();
    end
    checks++;
    if (drop_cnt2 !== 2'd3 || overflow2 !== 4'b1000) begin
      failures++;
      $display("FAIL sat_cnt2: cnt2=%0d ovf2=%b, required 3/1000", drop_cnt2, overflow2);
    end
    checks++;
    if (drop_cnt !== 8'd5) begin
      failures++;
      $display("FAIL sat_cnt8: cnt=%0d, required 5", drop_cnt);
    end
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    checks++;
    if (drop_cnt2 !== 2'd0 || overflow2 !== 4'b0000 || drop_cnt !== 8'd0 || overflow !== 4'b0000) begin
      failures++;
      $display("FAIL clr_alone: cnt=%0d ovf=%b cnt2=%0d ovf2=%b, required all 0", drop_cnt, overflow, drop_cnt2, overflow2);
    end
    drop_clr = 1'b1;
    a = 4'b1000;
    step();
    drop_clr = 1'b0;
    a = 4'b0000;
    checks++;
    if (drop_cnt !== 8'd1 || overflow !== 4'b1000 || drop_cnt2 !== 2'd1) begin
      failures++;
      $display("FAIL clr_vs_drop: cnt=%0d ovf=%b cnt2=%0d, required 1/1000/1", drop_cnt, overflow, drop_cnt2);
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    out_ready = 1'b1;
    a = 4'b0100; step(); a = 4'b0000; step(); step();
    out_ready = 1'b0;
    a = 4'b0110; step(); a = 4'b0000; step();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd1) begin
      failures++;
      $display("FAIL rr_wrap: valid=%b id=%0d, required valid=1 id=1", out_valid, out_id);
    end
    a = 4'b0010; step();
    rst = 1'b1; a = 4'b0000;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_id !== 2'd0) begin
      failures++;
      $display("FAIL rst_abandon: valid=%b id=%0d, required valid=0 id=0", out_valid, out_id);
    end
    out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_pending: valid=%b, required 0", out_valid);
    end
    a = 4'b1001; step(); a = 4'b0000; step();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      failures++;
      $display("FAIL rst_ptr: valid=%b id=%0d, required valid=1 id=0", out_valid, out_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_fairness();
    test_multi_drop();
    test_saturate_clear();
    test_reset_mid_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
